jtag_dtm_hs: RTL and testbench
==============================

# jtag_dtm_hs

Parametrised JTAG debug transport module with a handshaked DMI. It terminates the external JTAG port and implements the standard 16-state TAP with IDCODE, DTMCS, DMI and BYPASS registers. DMI accesses are issued to the debug module over a valid/ready request channel and a valid response channel, so the debug module may take any number of cycles to complete them. The block also tracks DMI status: sticky busy/failed reporting, dmireset and dmihardreset.

## Interface
- ABITS, 7: DMI address width; reported in dtmcs.abits.
- IR_LEN, 5: instruction register length, minimum 5.
- IDCODE_VAL, 32'h10e31913: IDCODE capture value; bit 0 must be 1.
- IDLE_HINT, 3'd1: dtmcs.idle field value.

Ports:
- tck_i  in  1  JTAG clock; the only clock.
- trst_i  in  1  reset; asynchronous, active-high.
- tms_i  in  1  TAP mode select.
- tdi_i  in  1  serial data in.
- tdo_o  out  1  serial data out, registered on falling tck_i.
- tdo_oe_o  out  1  high while in SHIFT_IR/SHIFT_DR, registered on falling tck_i.
- dmi_req_valid_o  out  1  request valid.
- dmi_req_ready_i  in  1  request accepted.
- dmi_req_op_o  out  2  1=read, 2=write.
- dmi_req_addr_o  out  ABITS  request address.
- dmi_req_data_o  out  32  write data.
- dmi_rsp_valid_i  in  1  response valid, one-cycle pulse.
- dmi_rsp_data_i  in  32  read data.
- dmi_rsp_err_i  in  1  response failed.
- dmi_hardreset_o  out  1  one-cycle pulse requesting debug module reset.

## Operation
- **TAP FSM**: standard IEEE 1149.1 transitions, advanced on rising tck_i. TEST_LOGIC_RESET is reached after 5 tms_i=1 from any state.
- **IR**:
  - CAPTURE_IR loads IR_LEN'b…00001.
  - SHIFT_IR shifts LSB-first, tdi_i into the MSB.
  - UPDATE_IR commits to the active IR.
  - TEST_LOGIC_RESET forces the active IR to IDCODE.
- **Opcodes**: IDCODE=0x01, DTMCS=0x10, DMI=0x11, BYPASS=0x1F. Every other opcode selects BYPASS.
- **IDCODE**: CAPTURE_DR loads IDCODE_VAL.
- **BYPASS**: 1 bit; CAPTURE_DR loads 0.
- **DTMCS**, 32 bits. CAPTURE_DR loads:
  - [3:0]=1, [9:4]=ABITS, [11:10]=sticky status, [14:12]=IDLE_HINT, all other bits 0.
  - UPDATE_DR: bit16=1 (dmireset) clears sticky status.
  - UPDATE_DR: bit17=1 (dmihardreset) pulses dmi_hardreset_o, clears sticky status, returns the transaction FSM to IDLE and abandons any outstanding transaction.
- **DMI** register: ABITS+34 bits as {addr, data[31:0], op[1:0]}. CAPTURE_DR loads {last addr, last response data, status}.
  - Status is the sticky value (0 ok, 2 failed, 3 busy).
  - If the transaction FSM is not IDLE at capture, status reads 3 and sticky is set to 3.
- **DMI UPDATE_DR**:
  - Sticky ≠ 0: ignored.
  - FSM not IDLE: sticky set to 3, request discarded.
  - Otherwise op 1 or 2 latches addr/data/op and enters REQ.
  - op 0 and op 3 do nothing.
- **Transaction FSM**:
  - IDLE → REQ on an accepted update.
  - REQ holds dmi_req_valid_o=1 with stable payload; on valid&&ready → RSP.
  - RSP on dmi_rsp_valid_i: latch dmi_rsp_data_i into the response-data register for reads (writes leave it unchanged); if dmi_rsp_err_i, sticky=2; → IDLE.
  - A response arriving in IDLE or REQ is ignored.
- **Sticky priority**: dmireset/hardreset clears beat a set in the same cycle; failed(2) is never overwritten by busy(3) and vice versa until cleared.
- **Response-data register**: reset 0; last addr: reset 0.

## Timing
- All state updates on rising tck_i; tdo_o and tdo_oe_o update on falling tck_i.
- tdo_o source: IR LSB in SHIFT_IR, else the LSB of the selected DR.
- Reset values: tdo_o=0, tdo_oe_o=0, dmi_req_valid_o=0, dmi_req_op_o=0, dmi_req_addr_o=0, dmi_req_data_o=0, dmi_hardreset_o=0.
- Internal reset state: TAP in TEST_LOGIC_RESET, IR=IDCODE, sticky=0, FSM IDLE.
- Request latency: dmi_req_valid_o rises the cycle after the UPDATE_DR state.
- dmi_req_valid_o falls the cycle after the valid&&ready handshake.
- Ready asserted in the same cycle valid rises completes the handshake in that cycle.
- dmi_rsp_valid_i in the same cycle as the handshake is not a response; it is ignored.
- trst_i mid-transaction: everything returns to reset immediately; dmi_req_valid_o drops without handshake. The debug module must tolerate this.
- TEST_LOGIC_RESET via tms_i does not cancel an outstanding DMI transaction and does not clear sticky status.

## Test plan
- **IDCODE after reset**: trst_i pulse, then shift 32 bits of DR → tdo_o yields 0x10e31913 LSB first; tdo_oe_o high only during shift.
- **BYPASS**: IR=0x1F then 0x0A; shift 8 bits 0xA5 → output delayed exactly one bit, first bit 0.
- **DMI write, slow ready**: DMI {addr=0x10, data=0x1, op=2}; ready 3 cycles late → dmi_req_valid_o high exactly 4 cycles with stable payload; next capture status=0.
- **DMI read**: op=1 addr=0x11; rsp data 0xDEADBEEF after 2 cycles → next DMI capture data=0xDEADBEEF, status=0.
- **Busy and error paths**:
  - Capture while waiting for a response → status 3; further updates are ignored.
  - DTMCS write with bit16 set → next capture status 0.
  - dmi_rsp_err_i → status 2.
- **Hardreset and mid-transaction reset**:
  - dmihardreset with a transaction in REQ → dmi_hardreset_o single pulse, valid drops, status 0.
  - trst_i while in RSP → all outputs at reset values.

Source files
------------

// File: rtl/jtag_dtm_hs.sv
// JTAG debug transport module: IEEE 1149.1 TAP with IDCODE/DTMCS/DMI/BYPASS
// and a valid/ready DMI request channel with sticky busy/failed status.
module jtag_dtm_hs #(
  parameter int          ABITS      = 7,
  parameter int          IR_LEN     = 5,
  parameter logic [31:0] IDCODE_VAL = 32'h10e31913,
  parameter logic [2:0]  IDLE_HINT  = 3'd1
) (
  input  logic             tck_i,
  input  logic             trst_i,
  input  logic             tms_i,
  input  logic             tdi_i,
  output logic             tdo_o,
  output logic             tdo_oe_o,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [1:0]       dmi_req_op_o,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [31:0]      dmi_req_data_o,
  input  logic             dmi_rsp_valid_i,
  input  logic [31:0]      dmi_rsp_data_i,
  input  logic             dmi_rsp_err_i,
  output logic             dmi_hardreset_o
);
  localparam int DRW = ABITS + 34;

  localparam logic [3:0] TLR    = 4'd0;
  localparam logic [3:0] RTI    = 4'd1;
  localparam logic [3:0] SEL_DR = 4'd2;
  localparam logic [3:0] CAP_DR = 4'd3;
  localparam logic [3:0] SH_DR  = 4'd4;
  localparam logic [3:0] EX1_DR = 4'd5;
  localparam logic [3:0] PA_DR  = 4'd6;
  localparam logic [3:0] EX2_DR = 4'd7;
  localparam logic [3:0] UP_DR  = 4'd8;
  localparam logic [3:0] SEL_IR = 4'd9;
  localparam logic [3:0] CAP_IR = 4'd10;
  localparam logic [3:0] SH_IR  = 4'd11;
  localparam logic [3:0] EX1_IR = 4'd12;
  localparam logic [3:0] PA_IR  = 4'd13;
  localparam logic [3:0] EX2_IR = 4'd14;
  localparam logic [3:0] UP_IR  = 4'd15;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_REQ  = 2'd1;
  localparam logic [1:0] T_RSP  = 2'd2;

  localparam logic [IR_LEN-1:0] OP_IDCODE = IR_LEN'(5'h01);
  localparam logic [IR_LEN-1:0] OP_DTMCS  = IR_LEN'(5'h10);
  localparam logic [IR_LEN-1:0] OP_DMI    = IR_LEN'(5'h11);

  logic [3:0]        state;
  logic [3:0]        nstate;
  logic [IR_LEN-1:0] ir;
  logic [IR_LEN-1:0] ir_sr;
  logic [DRW-1:0]    dr;
  logic [1:0]        tfsm;
  logic [1:0]        sticky;
  logic [31:0]       rsp_data;
  logic              hard_q;
  logic              tdo_q;
  logic              oe_q;

  logic sel_id, sel_cs, sel_dmi;
  logic cap_dr, sh_dr, up_dr;
  logic busy, up_cs, up_dmi, hard, clr;
  logic accept, rsp_ok, set_busy, set_err;

  always_comb begin
    nstate = TLR;
    unique case (state)
      TLR:     nstate = tms_i ? TLR    : RTI;
      RTI:     nstate = tms_i ? SEL_DR : RTI;
      SEL_DR:  nstate = tms_i ? SEL_IR : CAP_DR;
      CAP_DR:  nstate = tms_i ? EX1_DR : SH_DR;
      SH_DR:   nstate = tms_i ? EX1_DR : SH_DR;
      EX1_DR:  nstate = tms_i ? UP_DR  : PA_DR;
      PA_DR:   nstate = tms_i ? EX2_DR : PA_DR;
      EX2_DR:  nstate = tms_i ? UP_DR  : SH_DR;
      UP_DR:   nstate = tms_i ? SEL_DR : RTI;
      SEL_IR:  nstate = tms_i ? TLR    : CAP_IR;
      CAP_IR:  nstate = tms_i ? EX1_IR : SH_IR;
      SH_IR:   nstate = tms_i ? EX1_IR : SH_IR;
      EX1_IR:  nstate = tms_i ? UP_IR  : PA_IR;
      PA_IR:   nstate = tms_i ? EX2_IR : PA_IR;
      EX2_IR:  nstate = tms_i ? UP_IR  : SH_IR;
      UP_IR:   nstate = tms_i ? SEL_DR : RTI;
      default: nstate = TLR;
    endcase
  end

  assign sel_id  = ir == OP_IDCODE;
  assign sel_cs  = ir == OP_DTMCS;
  assign sel_dmi = ir == OP_DMI;
  assign cap_dr  = state == CAP_DR;
  assign sh_dr   = state == SH_DR;
  assign up_dr   = state == UP_DR;

  assign busy     = tfsm != T_IDLE;
  assign up_cs    = up_dr && sel_cs;
  assign up_dmi   = up_dr && sel_dmi;
  assign hard     = up_cs && dr[17];
  assign clr      = up_cs && (dr[16] || dr[17]);
  assign accept   = up_dmi && sticky == 2'd0 && !busy &&
                    (dr[1:0] == 2'd1 || dr[1:0] == 2'd2);
  assign rsp_ok   = tfsm == T_RSP && dmi_rsp_valid_i && !hard;
  assign set_busy = busy && ((cap_dr && sel_dmi) || up_dmi);
  assign set_err  = rsp_ok && dmi_rsp_err_i;

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state <= TLR;
      ir_sr <= IR_LEN'(1);
      ir    <= OP_IDCODE;
    end else begin
      state <= nstate;
      if (state == CAP_IR) ir_sr <= IR_LEN'(1);
      else if (state == SH_IR) ir_sr <= {tdi_i, ir_sr[IR_LEN-1:1]};
      if (state == TLR) ir <= OP_IDCODE;
      else if (state == UP_IR) ir <= ir_sr;
    end
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      dr <= '0;
    end else if (cap_dr) begin
      unique case (1'b1)
        sel_dmi: dr <= {dmi_req_addr_o, rsp_data, busy ? 2'd3 : sticky};
        sel_cs:  dr <= DRW'({17'd0, IDLE_HINT, sticky, 6'(ABITS), 4'd1});
        sel_id:  dr <= DRW'(IDCODE_VAL);
        default: dr <= '0;
      endcase
    end else if (sh_dr) begin
      unique case (1'b1)
        sel_dmi:        dr       <= {tdi_i, dr[DRW-1:1]};
        sel_cs, sel_id: dr[31:0] <= {tdi_i, dr[31:1]};
        default:        dr[0]    <= tdi_i;
      endcase
    end
  end

  // Clears win over sets; once non-zero, sticky holds until cleared.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) sticky <= 2'd0;
    else if (clr) sticky <= 2'd0;
    else if (sticky == 2'd0 && set_busy) sticky <= 2'd3;
    else if (sticky == 2'd0 && set_err) sticky <= 2'd2;
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      tfsm           <= T_IDLE;
      dmi_req_op_o   <= 2'd0;
      dmi_req_addr_o <= '0;
      dmi_req_data_o <= '0;
      rsp_data       <= '0;
      hard_q         <= 1'b0;
    end else begin
      hard_q <= hard;
      if (hard) begin
        tfsm <= T_IDLE;
      end else begin
        unique case (tfsm)
          T_IDLE: if (accept) begin
            tfsm           <= T_REQ;
            dmi_req_op_o   <= dr[1:0];
            dmi_req_data_o <= dr[33:2];
            dmi_req_addr_o <= dr[DRW-1:34];
          end
          T_REQ: if (dmi_req_ready_i) tfsm <= T_RSP;
          T_RSP: if (rsp_ok) begin
            if (dmi_req_op_o == 2'd1) rsp_data <= dmi_rsp_data_i;
            tfsm <= T_IDLE;
          end
          default: tfsm <= T_IDLE;
        endcase
      end
    end
  end

  always_ff @(negedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      tdo_q <= 1'b0;
      oe_q  <= 1'b0;
    end else begin
      tdo_q <= (state == SH_IR) ? ir_sr[0] : dr[0];
      oe_q  <= state == SH_IR || state == SH_DR;
    end
  end

  assign tdo_o           = tdo_q;
  assign tdo_oe_o        = oe_q;
  assign dmi_req_valid_o = tfsm == T_REQ;
  assign dmi_hardreset_o = hard_q;
endmodule

// File: tb/tb_jtag_dtm_hs.sv
// Randomised scoreboard bench for jtag_dtm_hs: JTAG scans and a DMI
// responder, checked against a transaction-level model of the DTM.
module tb_jtag_dtm_hs;
  localparam int ABITS = 7;
  localparam int DRW   = ABITS + 34;

  logic             tck_i = 1'b0;
  logic             trst_i = 1'b0;
  logic             tms_i = 1'b1;
  logic             tdi_i = 1'b0;
  logic             tdo_o;
  logic             tdo_oe_o;
  logic             dmi_req_valid_o;
  logic             dmi_req_ready_i = 1'b0;
  logic [1:0]       dmi_req_op_o;
  logic [ABITS-1:0] dmi_req_addr_o;
  logic [31:0]      dmi_req_data_o;
  logic             dmi_rsp_valid_i = 1'b0;
  logic [31:0]      dmi_rsp_data_i = '0;
  logic             dmi_rsp_err_i = 1'b0;
  logic             dmi_hardreset_o;

  jtag_dtm_hs #(
    .ABITS(ABITS), .IR_LEN(5),
    .IDCODE_VAL(32'h10e31913), .IDLE_HINT(3'd1)
  ) dut (
    .tck_i(tck_i), .trst_i(trst_i), .tms_i(tms_i), .tdi_i(tdi_i),
    .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_req_op_o(dmi_req_op_o), .dmi_req_addr_o(dmi_req_addr_o),
    .dmi_req_data_o(dmi_req_data_o), .dmi_rsp_valid_i(dmi_rsp_valid_i),
    .dmi_rsp_data_i(dmi_rsp_data_i), .dmi_rsp_err_i(dmi_rsp_err_i),
    .dmi_hardreset_o(dmi_hardreset_o)
  );

  always #10 tck_i = ~tck_i;

  int checks = 0;
  int failures = 0;

  typedef struct { string name; int len; logic [63:0] val; } scan_t;
  typedef struct { logic [1:0] op; logic [ABITS-1:0] addr; logic [31:0] data; } req_t;
  scan_t exp_scan[$];
  req_t  exp_req[$];
  int    exp_len[$];

  // Transaction-level model of the DTM's visible state
  logic [1:0]       m_sticky = 2'd0;
  bit               m_out = 1'b0;
  logic [1:0]       m_op = 2'd0;
  logic [ABITS-1:0] m_addr = '0;
  logic [31:0]      m_data = '0;

  bit          stall_ready = 0, stall_rsp = 0, abandon = 0, hs_done = 0;
  bit          err_en = 0, spur_en = 0, force_err = 0, force_dat = 0;
  int          force_rdy = -1, force_rd = -1;
  logic [31:0] force_val = '0;
  int          hr_cnt = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_tdo"}, 64'(tdo_o), 64'd0);
    chk({tag, "_oe"}, 64'(tdo_oe_o), 64'd0);
    chk({tag, "_valid"}, 64'(dmi_req_valid_o), 64'd0);
    chk({tag, "_op"}, 64'(dmi_req_op_o), 64'd0);
    chk({tag, "_addr"}, 64'(dmi_req_addr_o), 64'd0);
    chk({tag, "_data"}, 64'(dmi_req_data_o), 64'd0);
    chk({tag, "_hr"}, 64'(dmi_hardreset_o), 64'd0);
  endtask

  task automatic step(bit tms, bit tdi);
    @(negedge tck_i);
    tms_i = tms;
    tdi_i = tdi;
    @(posedge tck_i);
  endtask

  // Starts and ends in RUN_TEST_IDLE
  task automatic scan(bit ir, int len, logic [63:0] din, string name,
                      logic [63:0] expv);
    exp_scan.push_back('{name, len, expv});
    step(1, 0);
    if (ir) step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < len; i++) begin
      step(i == len - 1, din[i]);
      if (i == 0) chk({name, "_oe_shift"}, 64'(tdo_oe_o), 64'd1);
    end
    step(1, 0);
    step(0, 0);
    chk({name, "_oe_idle"}, 64'(tdo_oe_o), 64'd0);
  endtask

  task automatic set_ir(logic [4:0] op);
    scan(1, 5, 64'(op), "ir_capture", 64'd1);
  endtask

  task automatic dmi_scan(logic [1:0] op, logic [ABITS-1:0] addr,
                          logic [31:0] data, string name);
    logic [1:0] st;
    logic [63:0] capv;
    st = m_out ? 2'd3 : m_sticky;
    if (m_out && m_sticky == 2'd0) m_sticky = 2'd3;
    capv = 64'({m_addr, m_data, st});
    if (m_sticky == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
      exp_req.push_back('{op, addr, data});
      m_out = 1; m_op = op; m_addr = addr; hs_done = 0;
    end
    scan(0, DRW, 64'({addr, data, op}), name, capv);
  endtask

  task automatic dtmcs_scan(logic [31:0] din, string name);
    logic [63:0] capv;
    capv = 64'({17'd0, 3'd1, m_sticky, 6'(ABITS), 4'd1});
    if (din[16] || din[17]) m_sticky = 2'd0;
    scan(0, 32, 64'(din), name, capv);
  endtask

  task automatic wait_idle(string name);
    for (int i = 0; i < 300 && m_out; i++) @(negedge tck_i);
    chk({name, "_done"}, 64'(m_out), 64'd0);
  endtask

  task automatic wait_hs(string name);
    for (int i = 0; i < 300 && !hs_done; i++) @(negedge tck_i);
    chk({name, "_hs"}, 64'(hs_done), 64'd1);
  endtask

  // Scan monitor: gathers tdo bits while tdo_oe_o is high
  initial begin : scan_mon
    logic [63:0] got;
    int n;
    scan_t e;
    got = '0;
    n = 0;
    forever begin
      @(posedge tck_i);
      if (tdo_oe_o) begin
        if (n < 64) got = got | (64'(tdo_o) << n);
        n++;
      end else if (n > 0) begin
        if (exp_scan.size() == 0) begin
          chk("scan_unexpected", 64'(n), 64'd0);
        end else begin
          e = exp_scan.pop_front();
          chk({e.name, "_len"}, 64'(n), 64'(e.len));
          chk(e.name, got, e.val);
        end
        got = '0;
        n = 0;
      end
    end
  end

  // Request monitor: payload stability, handshake contents, valid duration
  initial begin : req_mon
    req_t cur, now, e;
    bit was, drop;
    int vc;
    was = 0; drop = 0; vc = 0;
    cur = '{2'd0, '0, '0};
    forever begin
      @(negedge tck_i);
      #1;
      now = '{dmi_req_op_o, dmi_req_addr_o, dmi_req_data_o};
      if (drop) chk("req_drop", 64'(dmi_req_valid_o), 64'd0);
      drop = 0;
      if (dmi_req_valid_o) begin
        if (was) chk("req_stable", 64'({now.op, now.addr, now.data}),
                     64'({cur.op, cur.addr, cur.data}));
        cur = now; was = 1; vc++;
        if (dmi_req_ready_i) begin
          if (exp_req.size() == 0) begin
            chk("req_unexpected", 64'(now.addr), 64'h1ff);
          end else begin
            e = exp_req.pop_front();
            chk("req_op", 64'(now.op), 64'(e.op));
            chk("req_addr", 64'(now.addr), 64'(e.addr));
            chk("req_data", 64'(now.data), 64'(e.data));
          end
          if (exp_len.size() > 0) chk("req_cycles", 64'(vc), 64'(exp_len.pop_front()));
          was = 0; vc = 0; drop = 1;
        end
      end else begin
        was = 0; vc = 0;
      end
    end
  end

  initial begin : hr_mon
    forever begin
      @(negedge tck_i);
      #1;
      if (dmi_hardreset_o) hr_cnt++;
    end
  end

  // Debug-module responder; updates the model when it answers
  initial begin : responder
    int d, rd, n;
    logic [31:0] rdata;
    bit err;
    forever begin
      @(negedge tck_i);
      dmi_rsp_valid_i = 0;
      dmi_rsp_err_i = 0;
      if (dmi_req_valid_o) begin
        d = force_rdy >= 0 ? force_rdy : int'($urandom_range(0, 3));
        n = 0;
        while ((stall_ready || n < d) && dmi_req_valid_o && n < 5000) begin
          @(negedge tck_i);
          n++;
        end
        if (dmi_req_valid_o) begin
          exp_len.push_back(n + 1);
          dmi_req_ready_i = 1;
          if (spur_en && $urandom_range(0, 2) == 0) begin
            dmi_rsp_valid_i = 1;
            dmi_rsp_err_i = 1;
          end
          @(negedge tck_i);
          dmi_req_ready_i = 0;
          dmi_rsp_valid_i = 0;
          dmi_rsp_err_i = 0;
          hs_done = 1;
          rd = force_rd >= 0 ? force_rd : int'($urandom_range(0, 2));
          n = 0;
          while ((stall_rsp || n < rd) && !abandon && n < 5000) begin
            @(negedge tck_i);
            n++;
          end
          if (!abandon) begin
            rdata = force_dat ? force_val : $urandom;
            err = force_err || (err_en && $urandom_range(0, 5) == 0);
            dmi_rsp_valid_i = 1;
            dmi_rsp_data_i = rdata;
            dmi_rsp_err_i = err;
            if (err && m_sticky == 2'd0) m_sticky = 2'd2;
            if (m_op == 2'd1) m_data = rdata;
            m_out = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #4000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] r;
    trst_i = 1;
    #1;
    chk_reset("reset");
    @(negedge tck_i);
    trst_i = 0;
    step(0, 0);

    scan(0, 32, 64'd0, "idcode", 64'h10e31913);
    set_ir(5'h1F);
    set_ir(5'h0A);
    scan(0, 8, 64'hA5, "bypass", 64'h4A);
    set_ir(5'h10);
    dtmcs_scan(32'd0, "dtmcs_init");

    set_ir(5'h11);
    force_rdy = 3;
    dmi_scan(2'd2, 7'h10, 32'h1, "dmi_w_cap");
    wait_idle("dmi_w");
    force_rdy = -1;
    force_rd = 2; force_dat = 1; force_val = 32'hDEADBEEF;
    dmi_scan(2'd1, 7'h11, 32'h0, "dmi_r_cap");
    wait_idle("dmi_r");
    force_rd = -1; force_dat = 0;
    dmi_scan(2'd0, 7'h0, 32'h0, "dmi_r_result");

    stall_rsp = 1;
    dmi_scan(2'd1, 7'h22, 32'h0, "busy_issue");
    wait_hs("busy");
    dmi_scan(2'd2, 7'h33, 32'h5, "busy_cap");
    stall_rsp = 0;
    wait_idle("busy");
    dmi_scan(2'd2, 7'h34, 32'h6, "busy_sticky");
    set_ir(5'h10);
    dtmcs_scan(32'h0001_0000, "dtmcs_busy");
    set_ir(5'h11);
    dmi_scan(2'd0, 7'h0, 32'h0, "after_dmireset");

    force_err = 1;
    dmi_scan(2'd2, 7'h05, 32'h1234_5678, "err_issue");
    wait_idle("err");
    force_err = 0;
    dmi_scan(2'd0, 7'h0, 32'h0, "err_status");
    repeat (5) step(1, 0);
    step(0, 0);
    scan(0, 32, 64'd0, "idcode_tlr", 64'h10e31913);
    set_ir(5'h11);
    dmi_scan(2'd0, 7'h0, 32'h0, "err_after_tlr");
    set_ir(5'h10);
    dtmcs_scan(32'h0001_0000, "dtmcs_err");

    set_ir(5'h11);
    err_en = 1; spur_en = 1;
    for (int it = 0; it < 40; it++) begin
      dmi_scan(2'($urandom_range(0, 3)), 7'($urandom), $urandom, "rnd");
      wait_idle("rnd");
      if (m_sticky != 2'd0 && $urandom_range(0, 1) == 1) begin
        r = $urandom;
        r[17] = 1'b0;
        r[16] = 1'b1;
        set_ir(5'h10);
        dtmcs_scan(r, "rnd_dtmcs");
        set_ir(5'h11);
      end
    end
    err_en = 0; spur_en = 0;
    set_ir(5'h10);
    dtmcs_scan(32'h0001_0000, "pre_hr");

    set_ir(5'h11);
    stall_ready = 1;
    dmi_scan(2'd2, 7'h44, 32'hCAFE_F00D, "hr_issue");
    set_ir(5'h10);
    hr_cnt = 0;
    dtmcs_scan(32'h0002_0000, "hr_cap");
    repeat (3) @(negedge tck_i);
    #2;
    chk("hr_pulse_cycles", 64'(hr_cnt), 64'd1);
    chk("hr_valid_low", 64'(dmi_req_valid_o), 64'd0);
    m_out = 0;
    exp_req.delete();
    stall_ready = 0;
    set_ir(5'h11);
    dmi_scan(2'd0, 7'h0, 32'h0, "hr_status");

    stall_rsp = 1;
    dmi_scan(2'd1, 7'h55, 32'h0, "trst_issue");
    wait_hs("trst");
    abandon = 1;
    @(negedge tck_i);
    #5;
    trst_i = 1;
    #1;
    chk_reset("trst_mid");
    m_sticky = 2'd0; m_out = 0; m_addr = '0; m_data = '0;
    @(negedge tck_i);
    trst_i = 0;
    stall_rsp = 0;
    repeat (3) @(negedge tck_i);
    abandon = 0;
    step(0, 0);
    step(0, 0);
    scan(0, 32, 64'd0, "idcode_trst", 64'h10e31913);
    set_ir(5'h11);
    dmi_scan(2'd0, 7'h0, 32'h0, "post_trst");

    repeat (4) @(negedge tck_i);
    chk("scan_queue_empty", 64'(exp_scan.size()), 64'd0);
    chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
